// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration register file: register map,
// frame FSM states, CONTROL bit positions and reset defaults.
package spi_cfg_pkg;

    typedef enum logic [1:0] {
        S_CMD,
        S_WR,
        S_RD
    } state_t;

    localparam logic [6:0] ADDR_ACC0    = 7'h00;
    localparam logic [6:0] ADDR_ACC1    = 7'h01;
    localparam logic [6:0] ADDR_ACC2    = 7'h02;
    localparam logic [6:0] ADDR_COEF    = 7'h03;
    localparam logic [6:0] ADDR_FACT    = 7'h04;
    localparam logic [6:0] ADDR_DAC     = 7'h05;
    localparam logic [6:0] ADDR_DITH    = 7'h06;
    localparam logic [6:0] ADDR_FLAGS   = 7'h07;
    localparam logic [6:0] ADDR_STATUS  = 7'h0E;
    localparam logic [6:0] ADDR_CONTROL = 7'h0F;
    localparam logic [6:0] ADDR_ID      = 7'h7F;

    localparam int unsigned CTRL_APPLY  = 0;
    localparam int unsigned CTRL_REVERT = 1;

    localparam logic [23:0] DEF_ACC_INC = 24'h01_0000;
    localparam logic [7:0]  DEF_COEF    = 8'd15;
    localparam logic [7:0]  DEF_FACT    = 8'd0;
    localparam logic [2:0]  DEF_DITH    = 3'd2;
    localparam logic [3:0]  DEF_FLAGS   = 4'h0;

endpackage

// File: rtl/spi_byte_shifter.sv
// Bit counter and rx/tx shift registers for one SPI byte lane; everything is
// cleared asynchronously by frame_rst (reset or chip select inactive).
module spi_byte_shifter (
    input  logic       spi_clk,
    input  logic       frame_rst,
    input  logic       mosi,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    output logic [2:0] bit_cnt,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       tx_msb
);

    logic [6:0] rx_shift;
    logic [7:0] tx_shift;

    // rx_byte includes the bit being sampled on this edge
    assign rx_byte   = {rx_shift, mosi};
    assign byte_done = (bit_cnt == 3'd7);
    assign tx_msb    = tx_shift[7];

    always_ff @(posedge spi_clk or posedge frame_rst) begin
        if (frame_rst) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
        end else begin
            bit_cnt  <= bit_cnt + 3'd1;
            rx_shift <= rx_byte[6:0];
            if (tx_load)
                tx_shift <= tx_data;
            else
                tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

endmodule

// File: rtl/spi_cfg_regfile.sv
// Addressed SPI register file with shadow/active double buffering for the
// FM transmitter configuration outputs.
module spi_cfg_regfile
    import spi_cfg_pkg::*;
#(
    parameter int unsigned N      = 18,
    parameter int unsigned K      = 4,
    parameter int unsigned L      = 2,
    parameter int unsigned D      = 5,
    parameter logic [7:0]  ID_VAL = 8'hA5
) (
    input  logic         spi_clk,
    input  logic         rst,
    input  logic         spi_csn,
    input  logic         spi_mosi,
    output logic         spi_miso,
    output logic [N-1:0] acc_inc,
    output logic [K-1:0] df_inc_coef,
    output logic [L-1:0] df_inc_fact,
    output logic [D-1:0] dac_ena,
    output logic [2:0]   dith_fact,
    output logic         usb_i2sn,
    output logic         audio_chan_sel,
    output logic         i2s_ws_align,
    output logic         spi_override,
    output logic         cfg_apply_tgl
);

    typedef struct packed {
        logic [N-1:0] acc;
        logic [K-1:0] coef;
        logic [L-1:0] fact;
        logic [D-1:0] dac;
        logic [2:0]   dith;
        logic [3:0]   flags;
    } cfg_t;

    localparam cfg_t CFG_DEF = '{
        acc:   N'(DEF_ACC_INC),
        coef:  K'(DEF_COEF),
        fact:  L'(DEF_FACT),
        dac:   {D{1'b1}},
        dith:  DEF_DITH,
        flags: DEF_FLAGS
    };

    cfg_t       sh, act;
    logic [4:0] apply_cnt;
    logic       dirty;
    state_t     state, state_nxt;
    logic [6:0] addr_ptr, addr_nxt, rd_addr;
    logic [7:0] rd_data, rx_byte;
    logic [2:0] bit_cnt;
    logic       byte_done, tx_load, tx_msb, wr_en;
    logic       frame_block, frame_rst;
    logic [23:0] sh_acc24;

    // A reset that lands inside a frame locks out the rest of that frame;
    // only a CSn rising edge re-arms decoding.
    always_ff @(posedge spi_csn or posedge rst) begin
        if (spi_csn)
            frame_block <= 1'b0;
        else
            frame_block <= 1'b1;
    end

    assign frame_rst = rst | spi_csn | frame_block;

    spi_byte_shifter u_shifter (
        .spi_clk   (spi_clk),
        .frame_rst (frame_rst),
        .mosi      (spi_mosi),
        .tx_load   (tx_load),
        .tx_data   (rd_data),
        .bit_cnt   (bit_cnt),
        .rx_byte   (rx_byte),
        .byte_done (byte_done),
        .tx_msb    (tx_msb)
    );

    always_ff @(posedge spi_clk or posedge frame_rst) begin
        if (frame_rst) begin
            state    <= S_CMD;
            addr_ptr <= '0;
        end else begin
            state    <= state_nxt;
            addr_ptr <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_ptr;
        rd_addr   = addr_ptr + 7'd1;
        wr_en     = 1'b0;
        tx_load   = 1'b0;
        if (byte_done) begin
            case (state)
                S_CMD: begin
                    addr_nxt = rx_byte[6:0];
                    rd_addr  = rx_byte[6:0];
                    if (rx_byte[7]) begin
                        state_nxt = S_RD;
                        tx_load   = 1'b1;
                    end else begin
                        state_nxt = S_WR;
                    end
                end
                S_WR: begin
                    wr_en    = 1'b1;
                    addr_nxt = addr_ptr + 7'd1;
                end
                S_RD: begin
                    tx_load  = 1'b1;
                    addr_nxt = addr_ptr + 7'd1;
                end
                default: state_nxt = S_CMD;
            endcase
        end
    end

    assign dirty    = (sh != act);
    assign sh_acc24 = 24'(sh.acc);

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_ACC0:   rd_data = sh_acc24[7:0];
            ADDR_ACC1:   rd_data = sh_acc24[15:8];
            ADDR_ACC2:   rd_data = sh_acc24[23:16];
            ADDR_COEF:   rd_data = 8'(sh.coef);
            ADDR_FACT:   rd_data = 8'(sh.fact);
            ADDR_DAC:    rd_data = 8'(sh.dac);
            ADDR_DITH:   rd_data = 8'(sh.dith);
            ADDR_FLAGS:  rd_data = 8'(sh.flags);
            ADDR_STATUS: rd_data = {dirty, 2'b00, apply_cnt};
            ADDR_ID:     rd_data = ID_VAL;
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            sh            <= CFG_DEF;
            act           <= CFG_DEF;
            apply_cnt     <= '0;
            cfg_apply_tgl <= 1'b0;
        end else if (wr_en) begin
            case (addr_ptr)
                ADDR_ACC0:  sh.acc[7:0]  <= rx_byte;
                ADDR_ACC1:  sh.acc[15:8] <= rx_byte;
                ADDR_ACC2:  sh.acc       <= N'({rx_byte, sh.acc[15:0]});
                ADDR_COEF:  sh.coef      <= K'(rx_byte);
                ADDR_FACT:  sh.fact      <= L'(rx_byte);
                ADDR_DAC:   sh.dac       <= D'(rx_byte);
                ADDR_DITH:  sh.dith      <= rx_byte[2:0];
                ADDR_FLAGS: sh.flags     <= rx_byte[3:0];
                ADDR_CONTROL: begin
                    if (rx_byte[CTRL_APPLY]) begin
                        act           <= sh;
                        apply_cnt     <= apply_cnt + 5'd1;
                        cfg_apply_tgl <= ~cfg_apply_tgl;
                    end else if (rx_byte[CTRL_REVERT]) begin
                        sh <= act;
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi_miso       = ~spi_csn & tx_msb;
    assign acc_inc        = act.acc;
    assign df_inc_coef    = act.coef;
    assign df_inc_fact    = act.fact;
    assign dac_ena        = act.dac;
    assign dith_fact      = act.dith;
    assign usb_i2sn       = act.flags[0];
    assign audio_chan_sel = act.flags[1];
    assign i2s_ws_align   = act.flags[2];
    assign spi_override   = act.flags[3];

endmodule

// File: tb/tb_spi_cfg_regfile.sv
// Self-checking bench for spi_cfg_regfile: directed table, multi-cycle corner
// sequences and randomized frames against a byte-array register model.
module tb_spi_cfg_regfile;

    localparam int N = 18;
    localparam int K = 4;
    localparam int L = 2;
    localparam int D = 5;

    logic         spi_clk = 1'b0;
    logic         rst = 1'b0;
    logic         spi_csn = 1'b1;
    logic         spi_mosi = 1'b0;
    logic         spi_miso;
    logic [N-1:0] acc_inc;
    logic [K-1:0] df_inc_coef;
    logic [L-1:0] df_inc_fact;
    logic [D-1:0] dac_ena;
    logic [2:0]   dith_fact;
    logic         usb_i2sn, audio_chan_sel, i2s_ws_align, spi_override;
    logic         cfg_apply_tgl;

    spi_cfg_regfile #(.N(N), .K(K), .L(L), .D(D), .ID_VAL(8'hA5)) dut (
        .spi_clk        (spi_clk),
        .rst            (rst),
        .spi_csn        (spi_csn),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .acc_inc        (acc_inc),
        .df_inc_coef    (df_inc_coef),
        .df_inc_fact    (df_inc_fact),
        .dac_ena        (dac_ena),
        .dith_fact      (dith_fact),
        .usb_i2sn       (usb_i2sn),
        .audio_chan_sel (audio_chan_sel),
        .i2s_ws_align   (i2s_ws_align),
        .spi_override   (spi_override),
        .cfg_apply_tgl  (cfg_apply_tgl)
    );

    always #5 spi_clk = ~spi_clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0]   txb[16];
    logic [7:0]   rxb[16];
    logic [N-1:0] mid_acc;
    logic         mid_miso;

    // reference model: register map as plain byte arrays
    logic [7:0] m_sh[8];
    logic [7:0] m_act[8];
    int         m_cnt;
    logic       m_tgl;

    typedef struct {
        logic [7:0]   b[4];
        int           nbytes;
        logic [N-1:0] acc;
        logic [2:0]   dith;
        logic [3:0]   flags;
        logic         tgl;
        logic [7:0]   status;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] m_mask(input int a);
        case (a)
            0, 1:    return 8'hFF;
            2:       return 8'((1 << (N - 16)) - 1);
            3:       return 8'((1 << K) - 1);
            4:       return 8'((1 << L) - 1);
            5:       return 8'((1 << D) - 1);
            6:       return 8'h07;
            7:       return 8'h0F;
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_reset();
        m_sh[0] = 8'h00; m_sh[1] = 8'h00; m_sh[2] = 8'h01; m_sh[3] = 8'h0F;
        m_sh[4] = 8'h00; m_sh[5] = m_mask(5); m_sh[6] = 8'h02; m_sh[7] = 8'h00;
        m_act = m_sh;
        m_cnt = 0;
        m_tgl = 1'b0;
    endtask

    function automatic logic m_dirty();
        for (int i = 0; i < 8; i++)
            if (m_sh[i] != m_act[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_write(input int a, input logic [7:0] d);
        if (a < 8) begin
            m_sh[a] = d & m_mask(a);
        end else if (a == 8'h0F) begin
            if (d[0]) begin
                m_act = m_sh;
                m_cnt = (m_cnt + 1) % 32;
                m_tgl = ~m_tgl;
            end else if (d[1]) begin
                m_sh = m_act;
            end
        end
    endtask

    function automatic logic [7:0] m_read(input int a);
        if (a < 8) return m_sh[a];
        if (a == 8'h0E) return {m_dirty(), 2'b00, 5'(m_cnt)};
        if (a == 8'h7F) return 8'hA5;
        return 8'h00;
    endfunction

    task automatic chk_outputs(input string tag);
        logic [23:0] acc24;
        acc24 = {m_act[2], m_act[1], m_act[0]};
        chk({tag, " acc_inc"}, 32'(acc_inc), 32'(acc24[N-1:0]));
        chk({tag, " coef"}, 32'(df_inc_coef), 32'(m_act[3]));
        chk({tag, " fact"}, 32'(df_inc_fact), 32'(m_act[4]));
        chk({tag, " dac"}, 32'(dac_ena), 32'(m_act[5]));
        chk({tag, " dith"}, 32'(dith_fact), 32'(m_act[6]));
        chk({tag, " flags"}, 32'({spi_override, i2s_ws_align, audio_chan_sel, usb_i2sn}), 32'(m_act[7]));
        chk({tag, " tgl"}, 32'(cfg_apply_tgl), 32'(m_tgl));
    endtask

    // Shifts nbits from txb (MSB first), sampling miso before each rising edge.
    // rst_on/rst_off (bit indices, -1 = unused) pulse rst inside the frame.
    task automatic spi_frame(input int nbits, input int rst_on, input int rst_off);
        mid_miso = 1'b0;
        @(negedge spi_clk);
        spi_csn = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            if (b != 0) @(negedge spi_clk);
            if (b == rst_on) rst = 1'b1;
            if (b == rst_off) rst = 1'b0;
            if (rst_on >= 0 && b == rst_on + 1) mid_acc = acc_inc;
            if (rst_on >= 0 && b > rst_on) mid_miso = mid_miso | spi_miso;
            rxb[b / 8][7 - (b % 8)] = spi_miso;
            spi_mosi = txb[b / 8][7 - (b % 8)];
        end
        @(negedge spi_clk);
        spi_csn  = 1'b1;
        spi_mosi = 1'b0;
        @(negedge spi_clk);
    endtask

    task automatic rd_reg(input logic [6:0] a, output logic [7:0] v);
        txb[0] = {1'b1, a};
        txb[1] = 8'h00;
        spi_frame(16, -1, -1);
        v = rxb[1];
    endtask

    task automatic do_reset();
        @(negedge spi_clk);
        spi_csn = 1'b1;
        rst = 1'b1;
        @(negedge spi_clk);
        @(negedge spi_clk);
        rst = 1'b0;
        @(negedge spi_clk);
    endtask

    function automatic logic [6:0] pick_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r < 8) return 7'(r);
        if (r == 8) return 7'h0E;
        if (r == 9) return 7'h0F;
        if (r == 10) return 7'h7F;
        if (r == 11) return 7'h7E;
        return 7'($urandom_range(0, 127));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  v;
        logic [7:0]  exp_rd[9];
        logic [39:0] fv;

        tbl[0] = '{'{8'h00, 8'h34, 8'h12, 8'h03}, 4, 18'h10000, 3'd2, 4'h0, 1'b0, 8'h80};
        tbl[1] = '{'{8'h0F, 8'h01, 8'h00, 8'h00}, 2, 18'h31234, 3'd2, 4'h0, 1'b1, 8'h01};
        tbl[2] = '{'{8'h06, 8'h05, 8'h00, 8'h00}, 2, 18'h31234, 3'd2, 4'h0, 1'b1, 8'h81};
        tbl[3] = '{'{8'h0F, 8'h02, 8'h00, 8'h00}, 2, 18'h31234, 3'd2, 4'h0, 1'b1, 8'h01};
        tbl[4] = '{'{8'h07, 8'hFF, 8'h00, 8'h00}, 2, 18'h31234, 3'd2, 4'h0, 1'b1, 8'h81};
        tbl[5] = '{'{8'h0F, 8'h03, 8'h00, 8'h00}, 2, 18'h31234, 3'd2, 4'hF, 1'b0, 8'h02};
        exp_rd = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h0F, 8'h00, 8'h1F, 8'h02, 8'h00};

        do_reset();
        m_reset();
        chk_outputs("reset");
        chk("reset miso", 32'(spi_miso), 32'd0);

        // ID then wrap to 0x00..0x07 in a single read burst
        txb[0] = 8'hFF;
        for (int i = 1; i < 10; i++) txb[i] = 8'h00;
        spi_frame(80, -1, -1);
        for (int i = 0; i < 9; i++)
            chk($sformatf("burst rd%0d", i), 32'(rxb[i + 1]), 32'(exp_rd[i]));

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 4; j++) txb[j] = tbl[i].b[j];
            spi_frame(8 * tbl[i].nbytes, -1, -1);
            chk($sformatf("tbl%0d acc", i), 32'(acc_inc), 32'(tbl[i].acc));
            chk($sformatf("tbl%0d dith", i), 32'(dith_fact), 32'(tbl[i].dith));
            chk($sformatf("tbl%0d flags", i),
                32'({spi_override, i2s_ws_align, audio_chan_sel, usb_i2sn}), 32'(tbl[i].flags));
            chk($sformatf("tbl%0d tgl", i), 32'(cfg_apply_tgl), 32'(tbl[i].tgl));
            rd_reg(7'h0E, v);
            chk($sformatf("tbl%0d status", i), 32'(v), 32'(tbl[i].status));
        end
        rd_reg(7'h06, v);  chk("revert dith shadow", 32'(v), 32'h02);
        rd_reg(7'h07, v);  chk("flags readback", 32'(v), 32'h0F);
        rd_reg(7'h0F, v);  chk("control reads 0", 32'(v), 32'h00);
        rd_reg(7'h10, v);  chk("unmapped reads 0", 32'(v), 32'h00);

        // partial data byte must be dropped, next frame decodes normally
        txb[0] = 8'h05;
        txb[1] = 8'hA8;
        spi_frame(13, -1, -1);
        rd_reg(7'h05, v);  chk("partial byte no write", 32'(v), 32'h1F);

        // rst mid-byte; bits after release would form "write 0x77 to 0x00"
        fv = {8'h03, 5'b10101, 8'h00, 8'h77, 11'd0};
        for (int i = 0; i < 5; i++) txb[i] = fv[39 - 8 * i -: 8];
        spi_frame(40, 11, 13);
        chk("rst immediate acc", 32'(mid_acc), 32'h10000);
        chk("rst frame miso", 32'(mid_miso), 32'd0);
        m_reset();
        chk_outputs("after rst");
        rd_reg(7'h00, v);  chk("rst frame ignored", 32'(v), 32'h00);
        rd_reg(7'h0E, v);  chk("rst status", 32'(v), 32'h00);

        do_reset();
        m_reset();
        for (int it = 0; it < 60; it++) begin
            int         op, len, a;
            logic [6:0] start;
            op = $urandom_range(0, 2);
            if (op == 0) begin
                start = pick_addr();
                len = $urandom_range(1, 3);
                txb[0] = {1'b0, start};
                for (int j = 1; j <= len; j++) txb[j] = 8'($urandom);
                spi_frame(8 * (len + 1), -1, -1);
                a = int'(start);
                for (int j = 1; j <= len; j++) begin
                    m_write(a, txb[j]);
                    a = (a + 1) % 128;
                end
            end else if (op == 1) begin
                txb[0] = 8'h0F;
                txb[1] = {4'($urandom), 2'b00, 2'($urandom_range(0, 3))};
                spi_frame(16, -1, -1);
                m_write(8'h0F, txb[1]);
            end else begin
                start = pick_addr();
                len = $urandom_range(1, 4);
                txb[0] = {1'b1, start};
                for (int j = 1; j <= len; j++) txb[j] = 8'($urandom);
                spi_frame(8 * (len + 1), -1, -1);
                a = int'(start);
                for (int j = 1; j <= len; j++) begin
                    chk($sformatf("rand%0d rd@%0h", it, a), 32'(rxb[j]), 32'(m_read(a)));
                    a = (a + 1) % 128;
                end
            end
            chk_outputs($sformatf("rand%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
